// File: rtl/ritc_multibuffer_address_generator.sv
// ---------------------------------------------------------------------------
// ritc_multibuffer_address_generator
//
// Write-side address generator for a multi-buffer sample store. A free-running
// ring address, stepped on every sync_i=1 edge, is concatenated with the
// current buffer index and sync_i to form the RAM write address. A small state
// machine moves through four states:
//   HOLDOFF  fills the pre-trigger history
//   ARMED    waits for a trigger
//   POST     records the programmable post-trigger length
//   FULL     stops writing while every buffer is occupied
// Each accepted trigger records its {ring,sync} address per buffer so that the
// readout knows where the event sits inside the ring.
//
// Ports
//   clk_i, reset_i    clock, asynchronous active-high reset
//   sync_i            sync phase, toggles every clock, write address LSB
//   trigger_i         trigger request pulse
//   clear_i           readout has finished with read_buffer_o
//   post_len_i        post-trigger length in sync periods minus 1
//   active_o          high while in POST
//   full_o            every buffer is occupied
//   trig_dropped_o    pulse: a trigger arrived outside ARMED
//   occupancy_o       number of filled, unread buffers
//   write_buffer_o    buffer currently being written
//   read_buffer_o     oldest filled buffer
//   read_trig_addr_o  recorded trigger address of read_buffer_o
//   write_addr_o      {write_buffer, ring, sync_i}
//   write_en_o        sample RAM write enable
// ---------------------------------------------------------------------------
module ritc_multibuffer_address_generator #(
    parameter int NBUF_BITS = 2,
    parameter int RING_BITS = 7
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           sync_i,
    input  logic                           trigger_i,
    input  logic                           clear_i,
    input  logic [RING_BITS-1:0]           post_len_i,
    output logic                           active_o,
    output logic                           full_o,
    output logic                           trig_dropped_o,
    output logic [NBUF_BITS:0]             occupancy_o,
    output logic [NBUF_BITS-1:0]           write_buffer_o,
    output logic [NBUF_BITS-1:0]           read_buffer_o,
    output logic [RING_BITS:0]             read_trig_addr_o,
    output logic [NBUF_BITS+RING_BITS:0]   write_addr_o,
    output logic                           write_en_o
);

    localparam int NBUF = 1 << NBUF_BITS;
    localparam logic [NBUF_BITS:0]   OCC_FULL = (NBUF_BITS+1)'(NBUF);
    localparam logic [RING_BITS-1:0] RING_MAX = '1;

    localparam logic [1:0] ST_ARMED   = 2'd0;
    localparam logic [1:0] ST_POST    = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;
    localparam logic [1:0] ST_FULL    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [RING_BITS-1:0] ring_q, ring_d;
    logic [RING_BITS-1:0] cnt_q, cnt_d;
    logic [RING_BITS-1:0] hold_len_q, hold_len_d;
    logic [RING_BITS-1:0] post_len_q, post_len_d;
    logic [NBUF_BITS-1:0] write_buffer_q, write_buffer_d;
    logic [NBUF_BITS-1:0] read_buffer_q, read_buffer_d;
    logic [NBUF_BITS:0]   occupancy_q, occupancy_d;
    logic                 full_q, full_d;
    logic                 write_en_q, write_en_d;
    logic                 active_q, active_d;
    logic                 trig_dropped_q, trig_dropped_d;

    logic [RING_BITS-1:0] target;
    logic                 period_end;
    logic                 commit;
    logic                 clear_ok;
    logic                 taddr_we;

    logic [NBUF-1:0][RING_BITS:0] taddr_flat;

    always_comb begin
        state_d        = state_q;
        ring_d         = sync_i ? ring_q + 1'b1 : ring_q;
        cnt_d          = sync_i ? cnt_q + 1'b1 : cnt_q;
        hold_len_d     = hold_len_q;
        post_len_d     = post_len_q;
        write_buffer_d = write_buffer_q;
        read_buffer_d  = read_buffer_q;
        write_en_d     = write_en_q;
        commit         = 1'b0;
        taddr_we       = 1'b0;
        clear_ok       = clear_i && (occupancy_q != '0);

        target     = (state_q == ST_POST) ? post_len_q : hold_len_q;
        period_end = sync_i && (cnt_q == target);

        case (state_q)
            ST_ARMED: begin
                if (trigger_i) begin
                    state_d    = ST_POST;
                    post_len_d = post_len_i;
                    taddr_we   = 1'b1;
                    cnt_d      = '0;
                end
            end
            ST_POST: begin
                if (period_end) begin
                    commit = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (period_end) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Resume only at a ring wrap so the refill starts at ring 0.
                if ((occupancy_q != OCC_FULL) && sync_i && (ring_q == RING_MAX)) begin
                    write_en_d = 1'b1;
                    state_d    = ST_HOLDOFF;
                    hold_len_d = '1;
                    cnt_d      = '0;
                end
            end
        endcase

        case ({commit, clear_ok})
            2'b10:   occupancy_d = occupancy_q + 1'b1;
            2'b01:   occupancy_d = occupancy_q - 1'b1;
            default: occupancy_d = occupancy_q;
        endcase

        if (commit) begin
            write_buffer_d = write_buffer_q + 1'b1;
            cnt_d          = '0;
            if (occupancy_d == OCC_FULL) begin
                state_d    = ST_FULL;
                write_en_d = 1'b0;
            end else begin
                // Pre-trigger holdoff tops the buffer up to one full ring.
                state_d    = ST_HOLDOFF;
                hold_len_d = ~post_len_q;
            end
        end

        if (clear_ok) begin
            read_buffer_d = read_buffer_q + 1'b1;
        end

        full_d         = (occupancy_d == OCC_FULL);
        active_d       = (state_d == ST_POST);
        trig_dropped_d = trigger_i && (state_q != ST_ARMED);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ST_HOLDOFF;
            ring_q         <= '0;
            cnt_q          <= '0;
            hold_len_q     <= '1;
            post_len_q     <= '0;
            write_buffer_q <= '0;
            read_buffer_q  <= '0;
            occupancy_q    <= '0;
            full_q         <= 1'b0;
            write_en_q     <= 1'b1;
            active_q       <= 1'b0;
            trig_dropped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_q         <= ring_d;
            cnt_q          <= cnt_d;
            hold_len_q     <= hold_len_d;
            post_len_q     <= post_len_d;
            write_buffer_q <= write_buffer_d;
            read_buffer_q  <= read_buffer_d;
            occupancy_q    <= occupancy_d;
            full_q         <= full_d;
            write_en_q     <= write_en_d;
            active_q       <= active_d;
            trig_dropped_q <= trig_dropped_d;
        end
    end

    // One trigger-address register per buffer; cleared by reset so the
    // readout never sees stale positions after a restart.
    genvar gi;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_taddr
            logic [RING_BITS:0] entry_q;
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    entry_q <= '0;
                end else if (taddr_we && (write_buffer_q == NBUF_BITS'(gi))) begin
                    entry_q <= {ring_q, sync_i};
                end
            end
            assign taddr_flat[gi] = entry_q;
        end
    endgenerate

    assign active_o         = active_q;
    assign full_o           = full_q;
    assign trig_dropped_o   = trig_dropped_q;
    assign occupancy_o      = occupancy_q;
    assign write_buffer_o   = write_buffer_q;
    assign read_buffer_o    = read_buffer_q;
    assign read_trig_addr_o = taddr_flat[read_buffer_q];
    assign write_addr_o     = {write_buffer_q, ring_q, sync_i};
    assign write_en_o       = write_en_q;

endmodule

// File: tb/tb_ritc_multibuffer_address_generator.sv
// ---------------------------------------------------------------------------
// Bench for ritc_multibuffer_address_generator (NBUF_BITS=2, RING_BITS=7).
// A behavioural model built from buffer bookkeeping and period countdowns is
// compared with every output on every clock. A table of long phases ends in
// hand-derived checkpoints; short directed sequences cover coincident
// commit/clear and an asynchronous reset during POST; a randomized run
// follows.
// ---------------------------------------------------------------------------
module tb_ritc_multibuffer_address_generator;

    localparam int NB   = 4;
    localparam int RING = 128;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       sync_i;
    logic       trigger_i;
    logic       clear_i;
    logic [6:0] post_len_i;
    logic       active_o;
    logic       full_o;
    logic       trig_dropped_o;
    logic [2:0] occupancy_o;
    logic [1:0] write_buffer_o;
    logic [1:0] read_buffer_o;
    logic [7:0] read_trig_addr_o;
    logic [9:0] write_addr_o;
    logic       write_en_o;

    ritc_multibuffer_address_generator #(.NBUF_BITS(2), .RING_BITS(7)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .sync_i           (sync_i),
        .trigger_i        (trigger_i),
        .clear_i          (clear_i),
        .post_len_i       (post_len_i),
        .active_o         (active_o),
        .full_o           (full_o),
        .trig_dropped_o   (trig_dropped_o),
        .occupancy_o      (occupancy_o),
        .write_buffer_o   (write_buffer_o),
        .read_buffer_o    (read_buffer_o),
        .read_trig_addr_o (read_trig_addr_o),
        .write_addr_o     (write_addr_o),
        .write_en_o       (write_en_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: mode 0 waiting for trigger, 1 post-trigger, 2 holdoff, 3 full.
    int m_mode, m_left, m_ring, m_wbuf, m_rbuf, m_occ, m_plen;
    int m_taddr [NB];
    bit m_wen, m_drop, m_active;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_mode = 2; m_left = RING; m_ring = 0; m_wbuf = 0; m_rbuf = 0;
        m_occ = 0; m_plen = 0; m_wen = 1; m_drop = 0; m_active = 0;
        for (int i = 0; i < NB; i++) m_taddr[i] = 0;
    endtask

    task automatic model_step(input bit trig, input bit clr, input int plen, input bit s);
        int mode_n;
        bit commit;
        bit clr_ok;
        int occ_before;
        mode_n = m_mode; commit = 0;
        clr_ok = clr && (m_occ > 0);
        occ_before = m_occ;
        m_drop = trig && (m_mode != 0);
        case (m_mode)
            0: if (trig) begin
                m_taddr[m_wbuf] = m_ring * 2 + int'(s);
                m_plen = plen; mode_n = 1; m_left = plen + 1;
            end
            1: if (s) begin m_left--; if (m_left == 0) commit = 1; end
            2: if (s) begin m_left--; if (m_left == 0) mode_n = 0; end
            default: if (occ_before < NB && s && m_ring == RING - 1) begin
                m_wen = 1; mode_n = 2; m_left = RING;
            end
        endcase
        if (clr_ok) begin m_rbuf = (m_rbuf + 1) % NB; m_occ--; end
        if (commit) begin
            m_wbuf = (m_wbuf + 1) % NB;
            m_occ++;
            if (m_occ == NB) begin mode_n = 3; m_wen = 0; end
            else begin mode_n = 2; m_left = RING - m_plen; end
        end
        if (s) m_ring = (m_ring + 1) % RING;
        m_mode = mode_n;
        m_active = (m_mode == 1);
    endtask

    task automatic compare_all();
        chk("active",       int'(active_o),         int'(m_active));
        chk("full",         int'(full_o),           int'(m_occ == NB));
        chk("trig_dropped", int'(trig_dropped_o),   int'(m_drop));
        chk("occupancy",    int'(occupancy_o),      m_occ);
        chk("write_buffer", int'(write_buffer_o),   m_wbuf);
        chk("read_buffer",  int'(read_buffer_o),    m_rbuf);
        chk("read_trig",    int'(read_trig_addr_o), m_taddr[m_rbuf]);
        chk("write_addr",   int'(write_addr_o),     m_wbuf * 256 + m_ring * 2 + int'(sync_i));
        chk("write_en",     int'(write_en_o),       int'(m_wen));
    endtask

    // One clock: apply inputs, compare against the model, clock both.
    task automatic cycle(input bit trig, input bit clr, input int plen);
        trigger_i  = trig;
        clear_i    = clr;
        post_len_i = 7'(plen);
        sync_i     = ~sync_i;
        #1;
        compare_all();
        @(posedge clk);
        model_step(trig, clr, plen, sync_i);
        cyc++;
        #1;
    endtask

    task automatic wait_armed(input int max_cycles);
        int got;
        got = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (m_mode == 0) begin got = 1; break; end
            cycle(0, 0, 0);
        end
        chk("wait_armed", got, 1);
    endtask

    typedef struct {
        string name;
        int    cycles;
        int    trig_every;
        bit    clr_first;
        int    plen;
        int    e_active, e_occ, e_wbuf, e_rbuf, e_full, e_wen, e_rta;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"holdoff_then_accept", 300, 20, 1'b0, 31, 1, 0, 0, 0, 0, 1, 5};
        vecs[1] = '{"post_commit",         300,  0, 1'b0, 31, 0, 1, 1, 0, 0, 1, 5};
        vecs[2] = '{"fill_to_full",       1000,  1, 1'b0,  5, 0, 4, 0, 0, 1, 0, 5};
        vecs[3] = '{"clear_from_full",     300,  0, 1'b1,  0, 0, 3, 0, 1, 0, 1, -1};

        reset_i = 1'b1; sync_i = 1'b0; trigger_i = 1'b0; clear_i = 1'b0; post_len_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        reset_i = 1'b0;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].cycles; i++)
                cycle(vecs[v].trig_every != 0 && (i % vecs[v].trig_every) == 0,
                      vecs[v].clr_first && i == 0, vecs[v].plen);
            chk({vecs[v].name, ".active"},    int'(active_o),       vecs[v].e_active);
            chk({vecs[v].name, ".occupancy"}, int'(occupancy_o),    vecs[v].e_occ);
            chk({vecs[v].name, ".wbuf"},      int'(write_buffer_o), vecs[v].e_wbuf);
            chk({vecs[v].name, ".rbuf"},      int'(read_buffer_o),  vecs[v].e_rbuf);
            chk({vecs[v].name, ".full"},      int'(full_o),         vecs[v].e_full);
            chk({vecs[v].name, ".wen"},       int'(write_en_o),     vecs[v].e_wen);
            if (vecs[v].e_rta >= 0)
                chk({vecs[v].name, ".read_trig"}, int'(read_trig_addr_o), vecs[v].e_rta);
            $display("phase %-20s occ=%0d wbuf=%0d rbuf=%0d full=%0d wen=%0d rta=%0d",
                     vecs[v].name, occupancy_o, write_buffer_o, read_buffer_o,
                     full_o, write_en_o, read_trig_addr_o);
        end

        // Commit coincident with clear at occupancy 2.
        cycle(0, 1, 0);
        chk("pre_coinc.occupancy", int'(occupancy_o), 2);
        chk("pre_coinc.rbuf",      int'(read_buffer_o), 2);
        wait_armed(700);
        if (sync_i == 1'b0) cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        chk("coinc.occupancy", int'(occupancy_o),    2);
        chk("coinc.wbuf",      int'(write_buffer_o), 1);
        chk("coinc.rbuf",      int'(read_buffer_o),  3);
        $display("coincident commit/clear occ=%0d wbuf=%0d rbuf=%0d",
                 occupancy_o, write_buffer_o, read_buffer_o);

        // Asynchronous reset in POST, then a clear at occupancy 0.
        wait_armed(700);
        cycle(1, 0, 31);
        repeat (10) cycle(0, 0, 31);
        chk("mid_post.active", int'(active_o), 1);
        reset_i = 1'b1;
        #1;
        model_reset();
        chk("rst.active",    int'(active_o),         0);
        chk("rst.occupancy", int'(occupancy_o),      0);
        chk("rst.wbuf",      int'(write_buffer_o),   0);
        chk("rst.rbuf",      int'(read_buffer_o),    0);
        chk("rst.full",      int'(full_o),           0);
        chk("rst.wen",       int'(write_en_o),       1);
        chk("rst.read_trig", int'(read_trig_addr_o), 0);
        chk("rst.write_addr",int'(write_addr_o),     int'(sync_i));
        compare_all();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        cycle(0, 1, 0);
        chk("clr_empty.rbuf",      int'(read_buffer_o), 0);
        chk("clr_empty.occupancy", int'(occupancy_o),   0);
        $display("reset mid-POST and clear at empty rbuf=%0d occ=%0d", read_buffer_o, occupancy_o);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(15) == 0, $urandom_range(299) == 0, int'($urandom_range(127)));
        $display("random run done occ=%0d wbuf=%0d rbuf=%0d", occupancy_o, write_buffer_o, read_buffer_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
